// File: rtl/cnt_intc_if.sv
// Shared cs/rw/addr slave bus used by the interrupt aggregator.
// The bus master drives select, direction, address and write data; the slave returns registered read data.
interface cnt_intc_if;
    logic        cs;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, output rw, output addr, output wdata, input rdata);
    modport slave  (input cs, input rw, input addr, input wdata, output rdata);
endinterface

// File: rtl/cnt_intc.sv
// Interrupt aggregator: rising-edge capture into sticky status, per-source mask, registered irq/irq_id.
// Optional INTC_OVF_EN adds a sticky overflow register at 0x14 for edges arriving on an already-set source.
module cnt_intc #(
    parameter int NUM_SRC = 10,
    parameter int ID_W    = 4
) (
    input  logic               clk,
    input  logic               xrst,
    cnt_intc_if.slave          bus,
    input  logic [NUM_SRC-1:0] int_src,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_MASK   = 8'h04;
    localparam logic [7:0] ADDR_PEND   = 8'h08;
    localparam logic [7:0] ADDR_ID     = 8'h0C;
    localparam logic [7:0] ADDR_CTRL   = 8'h10;
`ifdef INTC_OVF_EN
    localparam logic [7:0] ADDR_OVF    = 8'h14;
`endif

    logic [NUM_SRC-1:0] int_d;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] status;
    logic [NUM_SRC-1:0] mask;
    logic               gen;
    logic [31:0]        rdata_q;
`ifdef INTC_OVF_EN
    logic [NUM_SRC-1:0] ovf;
    logic [NUM_SRC-1:0] ovf_clr;
`endif

    logic [NUM_SRC-1:0] pend;
    logic               pend_any;
    logic [ID_W-1:0]    low_id;
    logic [NUM_SRC-1:0] low_hot;
    logic [NUM_SRC-1:0] status_clr;
    logic [31:0]        rd_val;
    logic               wr;
    logic               rd;
    logic               unused_wdata;

    assign wr           = bus.cs & ~bus.rw;
    assign rd           = bus.cs & bus.rw;
    assign bus.rdata    = rdata_q;
    assign unused_wdata = ^bus.wdata;

    // Scan from the top down so the lowest pending index is the one left standing.
    always_comb begin
        pend     = status & mask;
        pend_any = |pend;
        low_id   = '0;
        low_hot  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_id  = ID_W'(i);
                low_hot = NUM_SRC'(1) << i;
            end
        end
    end

    // Clears come from W1C writes and from acknowledging the reported source via an ID read.
    always_comb begin
        status_clr = '0;
        if (wr && bus.addr == ADDR_STATUS)
            status_clr = status_clr | bus.wdata[NUM_SRC-1:0];
        if (rd && bus.addr == ADDR_ID)
            status_clr = status_clr | low_hot;
`ifdef INTC_OVF_EN
        ovf_clr = '0;
        if (wr && bus.addr == ADDR_OVF)
            ovf_clr = bus.wdata[NUM_SRC-1:0];
`endif
    end

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            ADDR_STATUS: rd_val[NUM_SRC-1:0] = status;
            ADDR_MASK:   rd_val[NUM_SRC-1:0] = mask;
            ADDR_PEND:   rd_val[NUM_SRC-1:0] = pend;
            ADDR_ID: begin
                rd_val[31]       = pend_any;
                rd_val[ID_W-1:0] = low_id;
            end
            ADDR_CTRL:   rd_val[0] = gen;
`ifdef INTC_OVF_EN
            ADDR_OVF:    rd_val[NUM_SRC-1:0] = ovf;
`endif
            default:     rd_val = '0;
        endcase
    end

    // Edges are OR-ed in after clears, so a same-cycle edge always keeps its bit set.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            int_d   <= '0;
            edge_q  <= '0;
            status  <= '0;
            mask    <= '0;
            gen     <= 1'b0;
            rdata_q <= '0;
            irq     <= 1'b0;
            irq_id  <= '0;
`ifdef INTC_OVF_EN
            ovf     <= '0;
`endif
        end else begin
            int_d   <= int_src;
            edge_q  <= int_src & ~int_d;
            status  <= (status & ~status_clr) | edge_q;
            if (wr && bus.addr == ADDR_MASK)
                mask <= bus.wdata[NUM_SRC-1:0];
            if (wr && bus.addr == ADDR_CTRL)
                gen <= bus.wdata[0];
            rdata_q <= rd ? rd_val : 32'h0;
            irq     <= gen & pend_any;
            irq_id  <= low_id;
`ifdef INTC_OVF_EN
            ovf     <= (ovf & ~ovf_clr) | (edge_q & status);
`endif
        end
    end

endmodule

// File: tb/tb_cnt_intc.sv
// Directed self-checking bench for cnt_intc: capture, masking, read-to-ack, collisions, gen and reset.
// Build with +define+INTC_OVF_EN to also exercise the overflow register.
module tb_cnt_intc;

    logic       clk;
    logic       xrst;
    logic [9:0] int_src;
    logic       irq;
    logic [3:0] irq_id;
    int         checks;
    int         passes;

    cnt_intc_if bus_if ();

    cnt_intc #(.NUM_SRC(10), .ID_W(4)) dut (
        .clk     (clk),
        .xrst    (xrst),
        .bus     (bus_if),
        .int_src (int_src),
        .irq     (irq),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus_if.cs = 1'b1; bus_if.rw = 1'b0; bus_if.addr = a; bus_if.wdata = d;
        tick();
        bus_if.cs = 1'b0; bus_if.wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus_if.cs = 1'b1; bus_if.rw = 1'b1; bus_if.addr = a;
        tick();
        d = bus_if.rdata;
        bus_if.cs = 1'b0;
    endtask

    task automatic pulse(input logic [9:0] bits);
        int_src = int_src | bits;
        tick();
        int_src = int_src & ~bits;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        xrst = 1'b0;
        tick(2);
        checks++; if (bus_if.rdata !== 32'h0 || irq !== 1'b0 || irq_id !== 4'h0)
            $display("[TB] FAIL reset_outputs rdata=%h irq=%b id=%0d, required 0/0/0", bus_if.rdata, irq, irq_id);
        else passes++;
        xrst = 1'b1;
        tick();
        bus_read(8'h00, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL reset_status got %h required 0", d); else passes++;
    endtask

    task automatic test_capture();
        logic [31:0] d;
        bus_write(8'h04, 32'h3FF);
        bus_write(8'h10, 32'h1);
        pulse(10'h008);
        tick();
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_latency_early got %b required 0", irq); else passes++;
        tick();
        checks++; if (irq !== 1'b1 || irq_id !== 4'd3)
            $display("[TB] FAIL irq_src3 irq=%b id=%0d, required 1/3", irq, irq_id);
        else passes++;
        bus_read(8'h00, d);
        checks++; if (d !== 32'h008) $display("[TB] FAIL status_src3 got %h required 008", d); else passes++;
        tick();
        checks++; if (bus_if.rdata !== 32'h0) $display("[TB] FAIL rdata_idle got %h required 0", bus_if.rdata); else passes++;
        bus_write(8'h00, 32'h008);
        tick(2);
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_after_w1c got %b required 0", irq); else passes++;
    endtask

    task automatic test_priority_ack();
        logic [31:0] d;
        pulse(10'h084);
        tick(2);
        checks++; if (irq_id !== 4'd2) $display("[TB] FAIL prio_id got %0d required 2", irq_id); else passes++;
        bus_read(8'h0C, d);
        checks++; if (d !== 32'h80000002) $display("[TB] FAIL id_read1 got %h required 80000002", d); else passes++;
        bus_read(8'h0C, d);
        checks++; if (d !== 32'h80000007) $display("[TB] FAIL id_read2 got %h required 80000007", d); else passes++;
        bus_read(8'h0C, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL id_read_empty got %h required 0", d); else passes++;
        tick();
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_after_ack got %b required 0", irq); else passes++;
    endtask

    task automatic test_mask();
        logic [31:0] d;
        bus_write(8'h04, 32'h0);
        pulse(10'h020);
        tick(2);
        bus_read(8'h00, d);
        checks++; if (d !== 32'h020) $display("[TB] FAIL masked_status got %h required 020", d); else passes++;
        bus_read(8'h08, d);
        checks++; if (d !== 32'h0 || irq !== 1'b0)
            $display("[TB] FAIL masked_pend pend=%h irq=%b, required 0/0", d, irq);
        else passes++;
        bus_write(8'h04, 32'h020);
        checks++; if (irq !== 1'b0) $display("[TB] FAIL unmask_early got %b required 0", irq); else passes++;
        tick();
        checks++; if (irq !== 1'b1 || irq_id !== 4'd5)
            $display("[TB] FAIL unmask_irq irq=%b id=%0d, required 1/5", irq, irq_id);
        else passes++;
        bus_write(8'h04, 32'hFFFF_FFFF);
        bus_read(8'h04, d);
        checks++; if (d !== 32'h3FF) $display("[TB] FAIL mask_width got %h required 3FF", d); else passes++;
        bus_write(8'h18, 32'hFFFF_FFFF);
        bus_read(8'h18, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL unmapped_read got %h required 0", d); else passes++;
`ifndef INTC_OVF_EN
        bus_read(8'h14, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL ovf_absent got %h required 0", d); else passes++;
`endif
        bus_write(8'h00, 32'h3FF);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        pulse(10'h001);
        tick();
        int_src[0] = 1'b1;
        tick();
        int_src[0] = 1'b0;
        bus_write(8'h00, 32'h001);
        bus_read(8'h00, d);
        checks++; if (d !== 32'h001) $display("[TB] FAIL collision_set_wins got %h required 001", d); else passes++;
        bus_write(8'h00, 32'h001);
        bus_read(8'h00, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL plain_w1c got %h required 0", d); else passes++;
    endtask

    task automatic test_gen_and_reset();
        logic [31:0] d;
        pulse(10'h002);
        tick(2);
        checks++; if (irq !== 1'b1) $display("[TB] FAIL gen_on_irq got %b required 1", irq); else passes++;
        bus_write(8'h10, 32'h0);
        tick();
        checks++; if (irq !== 1'b0 || irq_id !== 4'd1)
            $display("[TB] FAIL gen_off irq=%b id=%0d, required 0/1", irq, irq_id);
        else passes++;
        bus_read(8'h08, d);
        checks++; if (d !== 32'h002) $display("[TB] FAIL gen_off_pend got %h required 002", d); else passes++;
        bus_write(8'h10, 32'h1);
        tick();
        bus_if.cs = 1'b1; bus_if.rw = 1'b1; bus_if.addr = 8'h08;
        xrst = 1'b0;
        int_src = 10'h010;
        tick();
        bus_if.cs = 1'b0;
        checks++; if (bus_if.rdata !== 32'h0 || irq !== 1'b0 || irq_id !== 4'h0)
            $display("[TB] FAIL midrun_reset rdata=%h irq=%b id=%0d, required 0/0/0", bus_if.rdata, irq, irq_id);
        else passes++;
        xrst = 1'b1;
        tick(2);
        bus_read(8'h00, d);
        checks++; if (d !== 32'h010) $display("[TB] FAIL held_through_reset got %h required 010", d); else passes++;
        int_src = 10'h0;
        bus_read(8'h04, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL mask_after_reset got %h required 0", d); else passes++;
        bus_write(8'h00, 32'h3FF);
    endtask

`ifdef INTC_OVF_EN
    task automatic test_overflow();
        logic [31:0] d;
        bus_write(8'h14, 32'h3FF);
        pulse(10'h200);
        tick();
        pulse(10'h200);
        tick();
        bus_read(8'h14, d);
        checks++; if (d !== 32'h200) $display("[TB] FAIL ovf_set got %h required 200", d); else passes++;
        bus_write(8'h14, 32'h200);
        bus_read(8'h14, d);
        checks++; if (d !== 32'h0) $display("[TB] FAIL ovf_clear got %h required 0", d); else passes++;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        xrst = 1'b0;
        int_src = 10'h0;
        bus_if.cs = 1'b0; bus_if.rw = 1'b0; bus_if.addr = 8'h0; bus_if.wdata = 32'h0;
        tick();
        test_reset();
        test_capture();
        test_priority_ack();
        test_mask();
        test_collision();
        test_gen_and_reset();
`ifdef INTC_OVF_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
